// File: rtl/ifetch_pkg.sv
// Shared widths and the {pc, inst} payload carried through the fetch stage.
package ifetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-to-decode valid/ready handshake carrying {pc, inst}.
interface ifetch_if;

    logic                          out_valid;
    logic                          out_ready;
    logic [ifetch_pkg::XLEN-1:0]   out_pc;
    logic [ifetch_pkg::XLEN-1:0]   out_inst;

    modport master (
        output out_valid,
        output out_pc,
        output out_inst,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_inst,
        output out_ready
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer for {pc, inst}; the input side passes straight through
// while empty and the held entry takes precedence once captured.
module fetch_skid
    import ifetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  fetch_pkt_t in_data,
    output logic       in_ready_c,
    output logic       out_valid_c,
    output fetch_pkt_t out_data_c,
    input  logic       out_ready
);

    logic       full;
    logic       full_next_c;
    fetch_pkt_t buf_q;

    // Fill when the presented word is not taken; drain once decode accepts.
    always_comb begin
        full_next_c = 1'b0;
        if (full) begin
            full_next_c = ~out_ready;
        end else begin
            full_next_c = in_valid & ~out_ready;
        end
    end

    assign in_ready_c  = ~full_next_c;
    assign out_valid_c = full | in_valid;
    assign out_data_c  = full ? buf_q : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            buf_q <= '0;
        end else if (flush) begin
            full  <= 1'b0;
        end else begin
            full <= full_next_c;
            if (!full && full_next_c) begin
                buf_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues imem reads, pairs each returned word
// with its PC and hands it to decode through a one-entry skid buffer.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    ifetch_if.master        dec
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic            resp_valid;
    logic            issue_c;
    logic            skid_out_valid_c;
    fetch_pkt_t      resp_pkt_c;
    fetch_pkt_t      out_pkt_c;

    assign resp_pkt_c = '{pc: resp_pc, inst: imem_rdata};

    fetch_skid u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect),
        .in_valid    (resp_valid),
        .in_data     (resp_pkt_c),
        .in_ready_c  (issue_c),
        .out_valid_c (skid_out_valid_c),
        .out_data_c  (out_pkt_c),
        .out_ready   (dec.out_ready)
    );

    // Redirect beats issue; without issue imem simply re-reads the held PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc & ~XLEN'(INST_BYTES - 1);
            resp_valid <= 1'b0;
        end else if (issue_c) begin
            pc         <= pc + XLEN'(INST_BYTES);
            resp_pc    <= pc;
            resp_valid <= 1'b1;
        end else begin
            resp_valid <= 1'b0;
        end
    end

    assign imem_addr     = pc;
    assign dec.out_valid = skid_out_valid_c & ~redirect;
    assign dec.out_pc    = out_pkt_c.pc;
    assign dec.out_inst  = out_pkt_c.inst;

endmodule

// File: tb/tb_ifetch.sv
// Directed and randomised checks of the fetch stage against a PC-sequence model.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    int          checks   = 0;
    int          failures = 0;

    ifetch_if dec_if ();

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec         (dec_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous imem: word i at byte address 4*i is A000_0000 + i.
    always @(posedge clk) imem_rdata <= word_at(imem_addr);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_if.out_ready = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (dec_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", dec_if.out_valid);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            checks++;
            if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'(4 * i) ||
                dec_if.out_inst !== 32'hA000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                         i, dec_if.out_valid, dec_if.out_pc, dec_if.out_inst,
                         32'(4 * i), 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            next_cycle(); dec_if.out_ready = 1'b0; #1;
            checks++;
            if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h10 ||
                dec_if.out_inst !== 32'hA000_0004) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=00000010 inst=a0000004",
                         i, dec_if.out_valid, dec_if.out_pc, dec_if.out_inst);
            end
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle(); dec_if.out_ready = 1'b1; #1;
            checks++;
            if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h10 + 32'(4 * k) ||
                dec_if.out_inst !== 32'hA000_0004 + 32'(k)) begin
                failures++;
                $display("FAIL stall_resume[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         k, dec_if.out_valid, dec_if.out_pc, 32'h10 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h43; #1;
        checks++;
        if (dec_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL redir_n_valid: got %b expected 0", dec_if.out_valid);
        end
        next_cycle(); redirect = 1'b0; #1;
        checks++;
        if (dec_if.out_valid !== 1'b0 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL redir_n1: got v=%b addr=%h expected v=0 addr=00000040",
                     dec_if.out_valid, imem_addr);
        end
        next_cycle(); #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h40 ||
            dec_if.out_inst !== 32'hA000_0010) begin
            failures++;
            $display("FAIL redir_n2: got v=%b pc=%h inst=%h expected v=1 pc=00000040 inst=a0000010",
                     dec_if.out_valid, dec_if.out_pc, dec_if.out_inst);
        end
        next_cycle(); #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h44) begin
            failures++;
            $display("FAIL redir_n3: got v=%b pc=%h expected v=1 pc=00000044",
                     dec_if.out_valid, dec_if.out_pc);
        end
    endtask

    task automatic test_redirect_skid();
        next_cycle(); dec_if.out_ready = 1'b0; #1;
        next_cycle(); #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h48) begin
            failures++;
            $display("FAIL skid_full: got v=%b pc=%h expected v=1 pc=00000048",
                     dec_if.out_valid, dec_if.out_pc);
        end
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h80; #1;
        checks++;
        if (dec_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL skid_redir_valid: got %b expected 0", dec_if.out_valid);
        end
        next_cycle(); redirect = 1'b0; dec_if.out_ready = 1'b1; #1;
        checks++;
        if (dec_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL skid_stale: got v=%b pc=%h expected v=0", dec_if.out_valid, dec_if.out_pc);
        end
        next_cycle(); #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h80 ||
            dec_if.out_inst !== 32'hA000_0020) begin
            failures++;
            $display("FAIL skid_target: got v=%b pc=%h inst=%h expected v=1 pc=00000080 inst=a0000020",
                     dec_if.out_valid, dec_if.out_pc, dec_if.out_inst);
        end
    endtask

    task automatic test_wrap();
        next_cycle(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        next_cycle(); redirect = 1'b0; #1;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr);
        end
        next_cycle(); #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'hFFFF_FFFC ||
            dec_if.out_inst !== 32'hDFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_top: got v=%b pc=%h inst=%h expected v=1 pc=fffffffc inst=dfffffff",
                     dec_if.out_valid, dec_if.out_pc, dec_if.out_inst);
        end
        next_cycle(); #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h0 ||
            dec_if.out_inst !== 32'hA000_0000 || $isunknown({dec_if.out_pc, dec_if.out_inst})) begin
            failures++;
            $display("FAIL wrap_zero: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=a0000000",
                     dec_if.out_valid, dec_if.out_pc, dec_if.out_inst);
        end
    endtask

    task automatic test_reset_stall();
        next_cycle(); dec_if.out_ready = 1'b0; #1;
        next_cycle(); #1;
        next_cycle(); rst = 1'b1; #1;
        next_cycle(); rst = 1'b0; dec_if.out_ready = 1'b1; #1;
        checks++;
        if (dec_if.out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_stall: got v=%b addr=%h expected v=0 addr=00000000",
                     dec_if.out_valid, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #1;
            checks++;
            if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'(4 * i) ||
                dec_if.out_inst !== 32'hA000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL rst_refetch[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         i, dec_if.out_valid, dec_if.out_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc    = 32'h8;
        logic        blank     = 1'b0;
        logic        hold      = 1'b0;
        int          transfers = 0;
        for (int c = 0; c < 10000; c++) begin
            next_cycle();
            dec_if.out_ready = ($urandom_range(0, 3) != 0);
            redirect         = ($urandom_range(0, 19) == 0);
            redirect_pc      = $urandom;
            #1;
            if (redirect) begin
                checks++;
                if (dec_if.out_valid !== 1'b0) begin
                    failures++; $display("FAIL rnd_redir[%0d]: got v=%b expected 0", c, dec_if.out_valid);
                end
                exp_pc = {redirect_pc[31:2], 2'b00};
                blank  = 1'b1;
                hold   = 1'b0;
            end else if (blank) begin
                checks++;
                if (dec_if.out_valid !== 1'b0) begin
                    failures++; $display("FAIL rnd_blank[%0d]: got v=%b expected 0", c, dec_if.out_valid);
                end
                blank = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (dec_if.out_valid !== 1'b1) begin
                        failures++; $display("FAIL rnd_hold[%0d]: got v=%b expected 1", c, dec_if.out_valid);
                    end
                end
                if (dec_if.out_valid === 1'b1) begin
                    checks++;
                    if (dec_if.out_pc !== exp_pc || dec_if.out_inst !== word_at(exp_pc)) begin
                        failures++;
                        $display("FAIL rnd_order[%0d]: got pc=%h inst=%h expected pc=%h inst=%h",
                                 c, dec_if.out_pc, dec_if.out_inst, exp_pc, word_at(exp_pc));
                    end
                    if (dec_if.out_ready) begin
                        exp_pc = exp_pc + 32'd4;
                        transfers++;
                    end
                end
                hold = (dec_if.out_valid === 1'b1) && !dec_if.out_ready;
            end
        end
        checks++;
        if (transfers < 3000) begin
            failures++; $display("FAIL rnd_throughput: got %0d transfers expected >= 3000", transfers);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_skid();
        test_wrap();
        test_reset_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
